// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
// Occupancy and readiness tracker for the reservation station. It picks the
// free slot for each dispatch, applies CDB wakeups to pending operand tags and
// offers one ready slot per cycle to the ALU, round-robin, over a valid/ready
// handshake. Payloads live in the datapath, indexed by alloc_idx / issue_idx.
//
// Ports
//   clk_in, rst_in        clock (rising edge), async active-low reset
//   rdy_in                global enable, low freezes all state
//   flush                 synchronous mispredict flush, clears every slot
//   disp_valid/ready      dispatch handshake from the decoder
//   disp_qj*/disp_qk*     source pending flags and their RoB tags
//   alloc_idx             slot written by the datapath on dispatch
//   cdb_valid, cdb_tag    common data bus broadcast
//   issue_valid/ready     issue handshake to the ALU
//   issue_idx             slot currently offered
//   full, count           registered occupancy
module rs_issue_scheduler #(
   parameter int RS_SIZE  = 16,
   parameter int RS_ADDR  = 4,
   parameter int ROB_ADDR = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush,
   input  logic                disp_valid,
   output logic                disp_ready,
   input  logic                disp_qj_busy,
   input  logic [ROB_ADDR-1:0] disp_qj,
   input  logic                disp_qk_busy,
   input  logic [ROB_ADDR-1:0] disp_qk,
   output logic [RS_ADDR-1:0]  alloc_idx,
   input  logic                cdb_valid,
   input  logic [ROB_ADDR-1:0] cdb_tag,
   output logic                issue_valid,
   output logic [RS_ADDR-1:0]  issue_idx,
   input  logic                issue_ready,
   output logic                full,
   output logic [RS_ADDR:0]    count
);

   logic [RS_SIZE-1:0]  busy_q, pj_q, pk_q;
   logic [ROB_ADDR-1:0] tj_q [RS_SIZE];
   logic [ROB_ADDR-1:0] tk_q [RS_SIZE];
   logic [RS_ADDR-1:0]  rr_ptr_q, hold_idx_q;
   logic                hold_q;
   logic [RS_ADDR:0]    count_q;

   logic [RS_SIZE-1:0]  eligible;
   logic [RS_ADDR-1:0]  sel_idx;
   logic                disp_fire, issue_fire;

   assign eligible = busy_q & ~pj_q & ~pk_q;
   assign count    = count_q;
   assign full     = (count_q == (RS_ADDR+1)'(RS_SIZE));

   // Lowest free slot: scanning downward lets the lowest index win last.
   always_comb begin
      alloc_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) alloc_idx = RS_ADDR'(i);
      end
   end

   // Round-robin pick starting at rr_ptr; index arithmetic wraps naturally
   // because RS_SIZE is a power of two.
   always_comb begin
      logic [RS_ADDR-1:0] cand;
      sel_idx = '0;
      cand    = '0;
      for (int k = RS_SIZE - 1; k >= 0; k--) begin
         cand = rr_ptr_q + RS_ADDR'(k);
         if (eligible[cand]) sel_idx = cand;
      end
   end

   assign disp_ready  = rdy_in & ~full & ~flush;
   assign issue_valid = rdy_in & ~flush & (hold_q | (|eligible));
   assign issue_idx   = hold_q ? hold_idx_q : sel_idx;
   assign disp_fire   = disp_valid & disp_ready;
   assign issue_fire  = issue_valid & issue_ready;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q     <= '0;
         pj_q       <= '0;
         pk_q       <= '0;
         rr_ptr_q   <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
         count_q    <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            tj_q[i] <= '0;
            tk_q[i] <= '0;
         end
      end else if (rdy_in) begin
         if (flush) begin
            busy_q   <= '0;
            pj_q     <= '0;
            pk_q     <= '0;
            rr_ptr_q <= '0;
            hold_q   <= 1'b0;
            count_q  <= '0;
         end else begin
            if (cdb_valid) begin
               for (int i = 0; i < RS_SIZE; i++) begin
                  if (busy_q[i] && tj_q[i] == cdb_tag) pj_q[i] <= 1'b0;
                  if (busy_q[i] && tk_q[i] == cdb_tag) pk_q[i] <= 1'b0;
               end
            end
            // Issue frees a busy slot and dispatch fills a free one, so the
            // two writes never target the same index.
            if (issue_fire) busy_q[issue_idx] <= 1'b0;
            if (disp_fire) begin
               busy_q[alloc_idx] <= 1'b1;
               tj_q[alloc_idx]   <= disp_qj;
               tk_q[alloc_idx]   <= disp_qk;
               pj_q[alloc_idx]   <= disp_qj_busy & ~(cdb_valid & (cdb_tag == disp_qj));
               pk_q[alloc_idx]   <= disp_qk_busy & ~(cdb_valid & (cdb_tag == disp_qk));
            end
            // A stalled offer is pinned so a newer eligible slot cannot
            // replace it before the ALU accepts.
            if (issue_fire) begin
               hold_q   <= 1'b0;
               rr_ptr_q <= issue_idx + RS_ADDR'(1);
            end else if (issue_valid) begin
               hold_q     <= 1'b1;
               hold_idx_q <= issue_idx;
            end
            count_q <= count_q + (RS_ADDR+1)'(disp_fire) - (RS_ADDR+1)'(issue_fire);
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;
   localparam int N = 16;

   logic       clk_in = 1'b0;
   logic       rst_in, rdy_in, flush, disp_valid, disp_qj_busy, disp_qk_busy;
   logic       cdb_valid, issue_ready;
   logic [3:0] disp_qj, disp_qk, cdb_tag;
   logic       disp_ready, issue_valid, full;
   logic [3:0] alloc_idx, issue_idx;
   logic [4:0] count;

   int checks   = 0;
   int failures = 0;

   // Reference model state: one record per slot plus pointer and pinned offer.
   bit m_busy[N], m_pj[N], m_pk[N];
   int m_tj[N], m_tk[N];
   int m_rr, m_hidx;
   bit m_hold;

   bit e_dr, e_iv, e_full;
   int e_alloc, e_iidx, e_cnt;

   rs_issue_scheduler #(.RS_SIZE(16), .RS_ADDR(4), .ROB_ADDR(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
      .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk),
      .alloc_idx(alloc_idx), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
      .full(full), .count(count)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 0; m_pj[i] = 0; m_pk[i] = 0; m_tj[i] = 0; m_tk[i] = 0;
      end
      m_rr = 0; m_hold = 0; m_hidx = 0;
   endfunction

   function automatic bit ready_slot(int s);
      return m_busy[s] && !m_pj[s] && !m_pk[s];
   endfunction

   function automatic void model_eval();
      bit any;
      int sel;
      e_cnt = 0;
      for (int i = 0; i < N; i++) e_cnt += int'(m_busy[i]);
      e_full = (e_cnt == N);
      e_dr   = rdy_in && !e_full && !flush;
      e_alloc = 0;
      for (int i = 0; i < N; i++) begin
         if (!m_busy[i]) begin e_alloc = i; break; end
      end
      any = 0; sel = 0;
      for (int k = 0; k < N; k++) begin
         if (ready_slot((m_rr + k) % N)) begin sel = (m_rr + k) % N; any = 1; break; end
      end
      e_iv   = rdy_in && !flush && (m_hold || any);
      e_iidx = m_hold ? m_hidx : sel;
   endfunction

   function automatic void model_commit();
      bit dfire, ifire;
      if (!rdy_in) return;
      if (flush) begin model_reset(); return; end
      dfire = disp_valid && e_dr;
      ifire = e_iv && issue_ready;
      if (cdb_valid) begin
         for (int i = 0; i < N; i++) begin
            if (m_busy[i] && m_tj[i] == int'(cdb_tag)) m_pj[i] = 0;
            if (m_busy[i] && m_tk[i] == int'(cdb_tag)) m_pk[i] = 0;
         end
      end
      if (ifire) m_busy[e_iidx] = 0;
      if (dfire) begin
         m_busy[e_alloc] = 1;
         m_tj[e_alloc] = int'(disp_qj);
         m_tk[e_alloc] = int'(disp_qk);
         m_pj[e_alloc] = disp_qj_busy && !(cdb_valid && cdb_tag == disp_qj);
         m_pk[e_alloc] = disp_qk_busy && !(cdb_valid && cdb_tag == disp_qk);
      end
      if (ifire) begin
         m_hold = 0; m_rr = (e_iidx + 1) % N;
      end else if (e_iv) begin
         m_hold = 1; m_hidx = e_iidx;
      end
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      #1;
      model_eval();
      chk("disp_ready", disp_ready, e_dr);
      chk("alloc_idx", alloc_idx, e_alloc);
      chk("issue_valid", issue_valid, e_iv);
      if (e_iv) chk("issue_idx", issue_idx, e_iidx);
      chk("count", count, e_cnt);
      chk("full", full, e_full);
      @(posedge clk_in);
      model_commit();
      @(negedge clk_in);
   endtask

   task automatic idle();
      rdy_in = 1; flush = 0; disp_valid = 0;
      disp_qj_busy = 0; disp_qj = 0; disp_qk_busy = 0; disp_qk = 0;
      cdb_valid = 0; cdb_tag = 0; issue_ready = 0;
   endtask

   task automatic disp(input bit jb, input int j, input bit kb, input int k);
      disp_valid = 1;
      disp_qj_busy = jb; disp_qj = 4'(j);
      disp_qk_busy = kb; disp_qk = 4'(k);
   endtask

   task automatic do_reset();
      rst_in = 0;
      idle();
      #2;
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_issue_idx", issue_idx, 0);
      chk("rst_alloc_idx", alloc_idx, 0);
      chk("rst_disp_ready", disp_ready, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      model_reset();
      @(negedge clk_in);
      rst_in = 1;
   endtask

   initial begin
      rst_in = 0;
      idle();
      @(negedge clk_in);

      // In-order fill of three ready instructions, then drain.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle(); disp(0, 0, 0, 0);
         #1;
         chk("t1_alloc", alloc_idx, i);
         chk("t1_iv", issue_valid, (i > 0) ? 1 : 0);
         tick();
      end
      idle(); issue_ready = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t1_issue_idx", issue_idx, i);
         tick();
      end
      idle(); #1; chk("t1_count", count, 0); chk("t1_iv_empty", issue_valid, 0); tick();

      // Pending source woken by CDB two cycles after dispatch.
      do_reset();
      idle(); disp(1, 5, 0, 0); tick();
      idle(); #1; chk("t2_iv_wait1", issue_valid, 0); tick();
      idle(); cdb_valid = 1; cdb_tag = 5; #1; chk("t2_iv_cdb", issue_valid, 0); tick();
      idle(); issue_ready = 1; #1; chk("t2_iv_after", issue_valid, 1); chk("t2_idx", issue_idx, 0); tick();
      idle(); tick();

      // Same-cycle bypass on both sources.
      do_reset();
      idle(); disp(1, 7, 0, 0); cdb_valid = 1; cdb_tag = 7; tick();
      idle(); disp(0, 0, 1, 3); cdb_valid = 1; cdb_tag = 3;
      #1; chk("t3_bypass_j", issue_valid, 1); chk("t3_idx", issue_idx, 0); tick();
      idle(); issue_ready = 1; tick();
      idle(); #1; chk("t3_bypass_k", issue_valid, 1); chk("t3_idx_k", issue_idx, 1); issue_ready = 1; tick();

      // Fill all slots, overflow attempt, then one issue frees slot 0.
      do_reset();
      for (int i = 0; i < N; i++) begin
         idle(); disp(0, 0, 0, 0); #1; chk("t4_alloc", alloc_idx, i); tick();
      end
      idle(); disp(0, 0, 0, 0);
      #1; chk("t4_full", full, 1); chk("t4_disp_ready", disp_ready, 0); chk("t4_count", count, 16);
      tick();
      idle(); issue_ready = 1; #1; chk("t4_count_hold", count, 16); tick();
      idle(); #1; chk("t4_full_clr", full, 0); chk("t4_alloc_freed", alloc_idx, 0); tick();

      // Slots 2 and 5 ready, stalled offer must stay pinned on 2.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         idle();
         if (i == 2 || i == 5) disp(0, 0, 0, 0);
         else disp(1, 9, 0, 0);
         tick();
      end
      for (int r = 0; r < 3; r++) begin
         idle(); #1; chk("t5_pinned", issue_idx, 2); tick();
      end
      idle(); issue_ready = 1; #1; chk("t5_accept2", issue_idx, 2); tick();
      idle(); issue_ready = 1; #1; chk("t5_next5", issue_idx, 5); chk("t5_iv", issue_valid, 1); tick();
      idle(); cdb_valid = 1; cdb_tag = 9; tick();
      idle(); #1; chk("t5_rr_wrap", issue_idx, 0); tick();

      // Flush with a pinned offer and a dispatch in flight.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(); disp(0, 0, 0, 0); tick();
      end
      idle(); disp(0, 0, 0, 0); flush = 1; cdb_valid = 1; cdb_tag = 2; issue_ready = 1;
      #1; chk("t6_iv_flush", issue_valid, 0); chk("t6_dr_flush", disp_ready, 0); tick();
      idle(); #1;
      chk("t6_count", count, 0); chk("t6_iv", issue_valid, 0); chk("t6_alloc", alloc_idx, 0);
      tick();
      idle(); disp(0, 0, 0, 0); tick();
      idle(); #1; chk("t6_offer", issue_valid, 1);
      rst_in = 0; #1;
      chk("t6_rst_iv", issue_valid, 0); chk("t6_rst_count", count, 0);
      model_reset();
      @(negedge clk_in);
      rst_in = 1;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rdy_in       = ($urandom_range(0, 9) != 0);
         flush        = rdy_in && ($urandom_range(0, 39) == 0);
         disp_valid   = ($urandom_range(0, 9) < 6);
         disp_qj_busy = $urandom_range(0, 1);
         disp_qj      = 4'($urandom_range(0, 7));
         disp_qk_busy = $urandom_range(0, 1);
         disp_qk      = 4'($urandom_range(0, 7));
         cdb_valid    = $urandom_range(0, 1);
         cdb_tag      = 4'($urandom_range(0, 7));
         issue_ready  = ($urandom_range(0, 9) < 5);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Control sequencer for the reservation station datapath. Tracks per-slot occupancy and operand-tag readiness, and picks the free slot for each dispatch. Applies CDB wakeups and selects one ready slot per cycle, round-robin, for issue to the ALU over a valid/ready handshake. The RS payload arrays (op, vj/vk, RoBindex) stay in the datapath, which is indexed by alloc_idx and issue_idx.

Parameters:
RS_SIZE, 16, number of RS slots (power of two, ≥2)
RS_ADDR, 4, log2(RS_SIZE)
ROB_ADDR, 4, RoB tag width (matches `RoB_addr)

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous reset, active-low
rdy_in  in  1  global enable; low = freeze all state
flush  in  1  RoB mispredict flush, synchronous
disp_valid  in  1  decoder presents an instruction
disp_ready  out  1  scheduler can accept a dispatch
disp_qj_busy  in  1  source j is waiting on a tag
disp_qj  in  ROB_ADDR  source j tag
disp_qk_busy  in  1  source k is waiting on a tag
disp_qk  in  ROB_ADDR  source k tag
alloc_idx  out  RS_ADDR  slot the datapath writes on dispatch
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  ROB_ADDR  broadcast RoB tag
issue_valid  out  1  a ready slot is offered to the ALU
issue_idx  out  RS_ADDR  offered slot
issue_ready  in  1  ALU accepts
full  out  1  all slots busy
count  out  RS_ADDR+1  busy slot count

Behaviour:
- Per-slot state: busy, pj, tj, pk, tk (pending flag and tag per source). Also: rr_ptr (RS_ADDR), hold (1), hold_idx (RS_ADDR).
- Reset (rst_in=0, async): all busy/pj/pk=0, rr_ptr=0, hold=0, count=0. Outputs: issue_valid=0, issue_idx=0, alloc_idx=0, disp_ready=1, full=0.
- Definitions: dispatch fire = disp_valid & disp_ready; issue fire = issue_valid & issue_ready.
- rdy_in=0: no register updates. disp_ready=0, issue_valid=0.
- disp_ready = rdy_in & !full & !flush. alloc_idx = lowest-index non-busy slot, combinational from registered busy. alloc_idx=0 when full.
- Dispatch fire at an edge: slot alloc_idx gets busy=1, tj/tk captured, pj/pk = disp_q*_busy.
  - Same-cycle bypass: if cdb_valid & cdb_tag==disp_qj, pj is written 0. Same rule for k.
- Wakeup at an edge with cdb_valid: every busy slot with pj & tj==cdb_tag clears pj. Same for k.
- A slot is eligible when busy & !pj & !pk, registered view. A wakeup or dispatch at edge N makes the slot eligible in cycle N+1. There is no combinational CDB→issue path.
- Selection when hold=0: first eligible slot scanning rr_ptr, rr_ptr+1, … with modulo RS_SIZE wrap.
- issue_valid = rdy_in & !flush & (hold | any eligible). issue_idx = hold ? hold_idx : selected.
- Stability: if issue_valid & !issue_ready at an edge, then hold=1 and hold_idx=issue_idx. The offer stays unchanged until accepted; a newly eligible slot never displaces it.
- Issue fire at an edge: busy[issue_idx]=0, hold=0, rr_ptr=issue_idx+1 (wraps).
- A slot freed at edge N can be allocated from cycle N+1 only. There is no same-cycle free-and-reuse.
- Dispatch and issue fire on the same edge: both apply, count unchanged.
- count and full are registered: count = number of busy slots, full = (count==RS_SIZE).
- flush=1 at an edge overrides everything:
  - all busy/pj/pk=0, hold=0, rr_ptr=0, count=0;
  - any dispatch, wakeup or issue in that cycle is dropped.
- Async reset mid-handshake: offer withdrawn immediately, no slot survives.

Test Plan:
- Reset then dispatch 3 instructions with no pending sources → alloc_idx 0,1,2 on consecutive cycles. issue_valid rises the cycle after the first dispatch. With issue_ready=1, issue_idx goes 0,1,2, then count=0.
- Dispatch slot0 with qj_busy, qj=5; CDB tag 5 two cycles later → issue_valid=0 until the cycle after the CDB edge, then issue_idx=0.
- Dispatch with qj=7 while cdb_valid, cdb_tag=7 in the same cycle → slot eligible next cycle (bypass).
- Fill 16 slots → full=1, disp_ready=0, a further disp_valid is ignored. One issue fire → full=0 next cycle, alloc_idx = the freed index.
- Slots 2 and 5 eligible, issue_ready=0 for 3 cycles → issue_idx stays 2. Accept, then issue_idx=5 next cycle, rr_ptr=6.
- Flush with 4 busy, hold=1, and disp_valid=1 → next cycle count=0, issue_valid=0, alloc_idx=0. Also drop rst_in low mid-offer → issue_valid=0 immediately.
